// File: rtl/encoder_fec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_fec_pkg
//  Description : Shared types and constants for the FEC encoder datapath:
//                message word type, default staging-buffer depth and the
//                bench clock half period.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_fec_pkg;

    // Width of one message word moved through the encoder datapath
    localparam int MESSAGE_WIDTH = 8;

    typedef logic [MESSAGE_WIDTH-1:0] message_data_t;

    // Default number of entries in a staging circular buffer
    localparam int CIRC_BUF_DEPTH = 16;

    // Half clock period used by benches that drive this datapath
    localparam int HALF_CLK_PERIOD = 5;

endpackage : encoder_fec_pkg
`default_nettype wire

// File: rtl/circular_buffer_mem.sv
`default_nettype none
// ============================================================================
//  Module      : circular_buffer_mem
//  Description : DEPTH x message_data_t storage array with a synchronous
//                write port and a registered, enable-gated read port. The
//                read register resets to zero; the array itself does not.
//  Revision    : 1.0 - initial release
// ============================================================================
module circular_buffer_mem
    import encoder_fec_pkg::*;
#(
    parameter  int DEPTH  = CIRC_BUF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  message_data_t       wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output message_data_t       rd_data
);

    message_data_t r_mem [DEPTH];
    message_data_t r_rd_data;

    // Write port: store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word; holds its value when not reading.
    // A same-edge write to the read address returns the old contents, which
    // is what a full buffer doing read+write into the freed slot needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : circular_buffer_mem
`default_nettype wire

// File: rtl/circular_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : circular_buffer
//  Description : Single-clock circular FIFO staging message words between
//                producer and consumer stages. Wrapping read/write pointers
//                address a DEPTH-entry RAM; an occupancy count drives the
//                empty/full flags. Read data is registered and qualified by
//                a one-cycle rd_valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module circular_buffer
    import encoder_fec_pkg::*;
#(
    parameter  int DEPTH  = CIRC_BUF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            rd_en,
    input  message_data_t   data_in,
    output message_data_t   data_out,
    output logic            empty,
    output logic            full,
    output logic            rd_valid
);

    localparam logic [ADDR_W-1:0] c_ptr_one   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_cnt_full  = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_rd_valid;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Flags are pure decodes of the registered count
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_full);

    // A read needs a stored word; a write needs room, or a read freeing a
    // slot in the same cycle (full buffer). No bypass when empty.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Write pointer: advance one slot per accepted write, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
    end

    // Read pointer: advance one slot per accepted read, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Occupancy: up on write only, down on read only, otherwise unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read strobe: high for exactly the cycle after each accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    circular_buffer_mem #(
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (data_out)
    );

    assign empty    = w_empty;
    assign full     = w_full;
    assign rd_valid = r_rd_valid;

endmodule : circular_buffer
`default_nettype wire

// File: tb/tb_circular_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circular_buffer
//  Description : Self-checking bench for circular_buffer. A queue-based
//                reference model tracks expected outputs every cycle; a
//                vector table and hand-written sequences cover the corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circular_buffer;
    import encoder_fec_pkg::*;

    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    message_data_t data_in;
    message_data_t data_out;
    logic          empty;
    logic          full;
    logic          rd_valid;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    message_data_t m_q[$];
    message_data_t m_dout = '0;
    bit            m_valid = 1'b0;

    typedef struct {
        bit            rst;
        bit            wr;
        bit            rd;
        message_data_t din;
        message_data_t exp_dout;
        bit            exp_valid;
        bit            exp_empty;
        bit            exp_full;
    } vec_t;

    circular_buffer #(
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #HALF_CLK_PERIOD clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: flags come from the occupancy before the edge
    task automatic model_update(input bit r, input bit w, input bit rd, input message_data_t d);
        bit was_empty;
        bit was_full;
        bit ra;
        bit wa;
        if (r) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
        end else begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == DEPTH);
            ra = rd && !was_empty;
            wa = w && (!was_full || ra);
            m_valid = ra;
            if (ra) m_dout = m_q.pop_front();
            if (wa) m_q.push_back(d);
        end
    endtask

    // Drive one cycle, advance past the edge, compare against the model
    task automatic step(input bit r, input bit w, input bit rd, input message_data_t d);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        model_update(r, w, rd, d);
        @(posedge clk);
        #1;
        check("model_data_out", 32'(data_out), 32'(m_dout));
        check("model_rd_valid", 32'(rd_valid), 32'(m_valid));
        check("model_empty",    32'(empty),    32'(m_q.size() == 0));
        check("model_full",     32'(full),     32'(m_q.size() == DEPTH));
    endtask

    initial begin
        vec_t vecs [12];
        int   rcv;
        int   sent;
        bit   w;
        bit   r;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // Reset hold
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check("reset_empty",    32'(empty),    32'd1);
        check("reset_full",     32'(full),     32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_data_out", 32'(data_out), 32'h00);

        // Vector table: {rst, wr, rd, din, data_out, rd_valid, empty, full}
        vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 1, 0};
        vecs[1]  = '{0, 1, 0, 8'hA1, 8'h00, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 8'hB2, 8'h00, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 8'hC3, 8'hA1, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 8'h00, 8'hB2, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 8'h00, 8'hC3, 1, 1, 0};
        vecs[6]  = '{0, 0, 1, 8'h00, 8'hC3, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 8'h33, 8'hC3, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 8'h00, 8'h33, 1, 1, 0};
        vecs[9]  = '{0, 1, 0, 8'hE5, 8'h33, 0, 0, 0};
        vecs[10] = '{1, 1, 1, 8'h66, 8'h00, 0, 1, 0};
        vecs[11] = '{0, 0, 1, 8'h00, 8'h00, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_empty", i),    32'(empty),    32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i),     32'(full),     32'(vecs[i].exp_full));
        end

        // Fill to full, drop an extra write, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 0, message_data_t'(i));
            check("fill_full", 32'(full), (i == DEPTH-1) ? 32'd1 : 32'd0);
        end
        step(0, 1, 0, 8'hAA);
        check("overflow_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 8'h00);
            check("drain_data",  32'(data_out), 32'(i));
            check("drain_valid", 32'(rd_valid), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(0, 0, 1, 8'h00);
        check("underflow_valid", 32'(rd_valid), 32'd0);
        check("underflow_data",  32'(data_out), 32'h0F);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, message_data_t'(8'h10 + i));
        step(0, 1, 1, 8'h55);
        check("fullrw_data",  32'(data_out), 32'h10);
        check("fullrw_valid", 32'(rd_valid), 32'd1);
        check("fullrw_full",  32'(full),     32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 8'h00);
            check("fullrw_drain", 32'(data_out), (i == DEPTH-1) ? 32'h55 : 32'(8'h11 + i));
        end
        check("fullrw_empty", 32'(empty), 32'd1);

        // Empty with simultaneous read and write
        step(0, 1, 1, 8'h33);
        check("emptyrw_valid", 32'(rd_valid), 32'd0);
        check("emptyrw_empty", 32'(empty),    32'd0);
        step(0, 0, 1, 8'h00);
        check("emptyrw_data",  32'(data_out), 32'h33);

        // Mid-operation reset with 5 stored words
        for (int i = 0; i < 5; i++) step(0, 1, 0, message_data_t'(8'h80 + i));
        step(1, 0, 0, 8'h00);
        check("midrst_empty", 32'(empty),    32'd1);
        check("midrst_data",  32'(data_out), 32'h00);
        step(0, 1, 0, 8'h77);
        step(0, 1, 0, 8'h78);
        step(0, 0, 1, 8'h00);
        check("midrst_first", 32'(data_out), 32'h77);
        step(0, 0, 1, 8'h00);
        check("midrst_second", 32'(data_out), 32'h78);
        check("midrst_drained", 32'(empty), 32'd1);

        // Flag-gated streaming of 40 words
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 2000 && rcv < 40; cyc++) begin
            w = (sent < 40) && !full && ($urandom_range(3) != 0);
            r = !empty && ($urandom_range(2) != 0);
            step(0, w, r, message_data_t'(8'h40 + sent));
            if (w) sent++;
            if (rd_valid) begin
                check("stream_data", 32'(data_out), 32'(8'h40 + rcv));
                rcv++;
            end
        end
        check("stream_count", 32'(rcv), 32'd40);

        // Unconstrained random traffic against the model
        for (int cyc = 0; cyc < 800; cyc++) begin
            step(($urandom_range(63) == 0), $urandom_range(1) == 1,
                 $urandom_range(1) == 1, message_data_t'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_circular_buffer
`default_nettype wire

// File: doc/circular_buffer.md
# circular_buffer

Synchronous single-clock circular FIFO that stages `message_data_t` words between producer and consumer stages of the FEC encoder datapath. Writes are accepted while not full and reads while not empty. Read data is registered and flagged by a one-cycle `rd_valid` strobe. Storage is a DEPTH-entry RAM addressed by wrapping read/write pointers.

## Interface
Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- wr_en  input  1  write request for `data_in` this cycle.
- rd_en  input  1  read request this cycle.
- data_in  input  message_data_t  word to store.
- data_out  output  message_data_t  registered read data.
- empty  output  1  no stored entries.
- full  output  1  DEPTH stored entries.
- rd_valid  output  1  `data_out` was updated by an accepted read at the last edge.

## Operation
- State registers:
  - wr_ptr and rd_ptr, each ADDR_W bits.
  - count, ADDR_W+1 bits, range 0..DEPTH.
- Outputs `empty` and `full` are decoded from count:
  - `empty` = (count == 0).
  - `full` = (count == DEPTH).
- Accepted write: wr_acc = wr_en & (!full | rd_acc).
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Accepted read: rd_acc = rd_en & !empty.
  - data_out <= mem[rd_ptr].
  - rd_ptr increments modulo DEPTH.
  - rd_valid <= 1.
- When no read is accepted, rd_valid <= 0 and data_out holds its last value.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- Rejected requests do not change state and produce no error signal:
  - Write while full with no accepted read.
  - Read while empty.
- Simultaneous rd_en and wr_en:
  - Empty: the write is accepted and the read is rejected. There is no bypass, so rd_valid stays 0.
  - Full: both are accepted. The oldest word is read, the new word goes into the freed slot, and count stays at DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- Ordering is strict FIFO. Data read equals data written, in order, across any number of pointer wraps.
- Reset, including mid-operation:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, rd_valid = 0, empty = 1, full = 0.
  - Memory contents are not reset and are unreachable until rewritten.
  - Reset overrides wr_en and rd_en in the same cycle.

## Timing
- Write latency:
  - Data written at edge N is readable by a read request sampled at edge N+1.
  - `empty` deasserts after edge N.
- Read latency is 1 cycle. rd_en is sampled at edge N with count > 0, then after edge N `data_out` holds the word and `rd_valid` = 1 for exactly one cycle.
- Back-to-back reads every cycle yield one word per cycle, with `rd_valid` held high continuously.
- `empty` and `full` are pure decodes of registered count. They change only after a clock edge; there is no combinational path from wr_en or rd_en.
- Producer and consumer must sample `full` and `empty` in the same cycle they assert a request. Requests that violate a flag are dropped as described under Operation.

## Structure
- Shared package encoder_fec_pkg holds:
  - MESSAGE_WIDTH (8).
  - typedef message_data_t (logic [MESSAGE_WIDTH-1:0]).
  - Default buffer depth constant.
  - HALF_CLK_PERIOD for benches.
- One natural sub-module: circular_buffer_mem, a DEPTH x message_data_t RAM with synchronous write port and registered read port.
- Pointer, count and flag logic live in the top module.

## Test plan
- Reset hold then release → empty=1, full=0, rd_valid=0, data_out=0.
- Write 16 words 0x00..0x0F with no reads:
  - full=1 after the 16th edge.
  - A 17th write of 0xAA is dropped.
  - Draining then returns 0x00..0x0F, with rd_valid=1 on each of 16 consecutive cycles.
  - empty=1 after the last read.
  - A further rd_en leaves rd_valid=0 and data_out=0x0F.
- Concurrent streaming of 40 words, with wr_en and rd_en driven simultaneously and both gated by the flags → output sequence exactly matches input across two pointer wraps.
- Full plus simultaneous rd_en and wr_en (0x55) → data_out=oldest word, count stays 16, and 0x55 is read out last.
- Empty plus simultaneous rd_en and wr_en (0x33) → rd_valid=0 that cycle, empty=0 afterwards, and the next read returns 0x33.
- Assert rst with 5 words stored → empty=1 next cycle, and subsequent writes and reads start from pointer 0 with no stale data returned.
